// File: rtl/counter_sequencer.sv
// counter_sequencer: buffers stop values, arms the Counter for each one and reports the measured run.
// Latency: idle push to result in 4+S cycles for stop S; a full FIFO refuses input and results hold until res_ready.

module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    // Extra pointer bit tells a full wrap apart from empty.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

module counter_sequencer #(
    parameter int INPUT_WIDTH = 8,
    parameter int DEPTH       = 4,
    parameter int CNT_WIDTH   = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INPUT_WIDTH-1:0] in_stop,
    output logic                   ctr_reset_l,
    output logic [INPUT_WIDTH-1:0] ctr_stop,
    input  logic                   ctr_done,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [INPUT_WIDTH-1:0] res_stop,
    output logic [CNT_WIDTH-1:0]   res_cycles,
    output logic                   res_timeout,
    output logic                   res_mismatch,
    output logic                   busy
);
    localparam int MW = (CNT_WIDTH > INPUT_WIDTH) ? CNT_WIDTH : INPUT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL  = CNT_WIDTH'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ARM, WAIT, REPORT} state_t;

    state_t                 state;
    logic [INPUT_WIDTH-1:0] cur_stop;
    logic [CNT_WIDTH-1:0]   wait_cnt;
    logic [INPUT_WIDTH-1:0] fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;

    sync_fifo #(.W(INPUT_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (in_valid && !fifo_full),
        .push_dat (in_stop),
        .pop      (state == ARM),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cur_stop    <= '0;
            wait_cnt    <= '0;
            res_cycles  <= '0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!fifo_empty) state <= ARM;
                ARM: begin
                    cur_stop <= fifo_head;
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // done takes priority over a timeout landing on the same cycle
                    if (ctr_done) begin
                        res_cycles  <= wait_cnt;
                        res_timeout <= 1'b0;
                        state       <= REPORT;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        res_cycles  <= TIMEOUT_VAL;
                        res_timeout <= 1'b1;
                        state       <= REPORT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_WIDTH'(1);
                    end
                end
                REPORT: if (res_ready) state <= fifo_empty ? IDLE : ARM;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready     = !fifo_full;
    assign ctr_reset_l  = (state == WAIT);
    assign ctr_stop     = (state == ARM) ? fifo_head : cur_stop;
    assign res_valid    = (state == REPORT);
    assign res_stop     = cur_stop;
    assign res_mismatch = res_timeout || (MW'(res_cycles) != MW'(cur_stop));
    assign busy         = (state != IDLE) || !fifo_empty;
endmodule
